// File: rtl/hazard_pkg.sv
// Shared hazard-unit constants: register file geometry and producer latency classes.
package hazard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int MAX_LAT    = 3;
    localparam int LAT_W      = 2;

    localparam logic [LAT_W-1:0] LAT_ALU  = 2'd0;
    localparam logic [LAT_W-1:0] LAT_LOAD = 2'd1;
    localparam logic [LAT_W-1:0] LAT_MUL  = 2'd3;

endpackage

// File: rtl/hazard_timer.sv
// One scoreboard entry: countdown of cycles until a pending result becomes forwardable.
module hazard_timer #(
    parameter int LAT_W = hazard_pkg::LAT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [LAT_W-1:0] value,
    output logic             nonzero
);

    logic [LAT_W-1:0] count;

    // A fresh producer overrides any countdown still in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - LAT_W'(1);
        end
    end

    assign nonzero = |count;

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard-based hazard unit: per-register latency timers drive load-use stalls,
// plus branch/jump flush controls and a stall-cycle counter.
module hazard_scoreboard #(
    parameter int REG_ADDR_W = hazard_pkg::REG_ADDR_W,
    parameter int NUM_REGS   = hazard_pkg::NUM_REGS,
    parameter int MAX_LAT    = hazard_pkg::MAX_LAT,
    parameter int LAT_W      = hazard_pkg::LAT_W,
    parameter int PERF_W     = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_id_rs,
    input  logic [REG_ADDR_W-1:0] i_id_rt,
    input  logic                  i_id_rs_used,
    input  logic                  i_id_rt_used,
    input  logic                  i_id_wr_en,
    input  logic [REG_ADDR_W-1:0] i_id_rd,
    input  logic [LAT_W-1:0]      i_id_lat,
    input  logic                  i_jump,
    input  logic                  i_branch_taken,
    output logic                  o_pc_keep,
    output logic                  o_IF_ID_keep,
    output logic                  o_IF_ID_flush,
    output logic                  o_ID_EX_flush,
    output logic                  o_busy,
    output logic [PERF_W-1:0]     o_stall_cycles
);

    import hazard_pkg::*;

    function automatic logic [LAT_W-1:0] sat_lat(input logic [LAT_W-1:0] lat);
        if (int'(lat) > MAX_LAT) begin
            return LAT_W'(MAX_LAT);
        end
        return lat;
    endfunction

    logic [NUM_REGS-1:0] busy_vec;
    logic                hit_rs;
    logic                hit_rt;
    logic                stall;
    logic                issue;
    logic [LAT_W-1:0]    lat_sat;

    // Register 0 is hardwired to zero, so it never carries a pending result.
    assign busy_vec[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_timer
        hazard_timer #(
            .LAT_W(LAT_W)
        ) u_timer (
            .clk    (i_clk),
            .rst_n  (i_rst_n),
            .load   (issue && i_id_wr_en && (i_id_rd == REG_ADDR_W'(r))),
            .value  (lat_sat),
            .nonzero(busy_vec[r])
        );
    end

    assign lat_sat = sat_lat(i_id_lat);
    assign hit_rs  = i_id_rs_used && busy_vec[i_id_rs];
    assign hit_rt  = i_id_rt_used && busy_vec[i_id_rt];

    // A taken branch squashes the ID instruction, so it neither stalls nor issues.
    assign stall = i_id_valid && (hit_rs || hit_rt) && !i_branch_taken;
    assign issue = i_id_valid && !stall && !i_branch_taken;

    assign o_pc_keep     = stall;
    assign o_IF_ID_keep  = stall;
    assign o_ID_EX_flush = stall || i_branch_taken;
    assign o_IF_ID_flush = i_branch_taken || (i_jump && !stall);
    assign o_busy        = |busy_vec;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stall_cycles <= '0;
        end else if (stall) begin
            o_stall_cycles <= o_stall_cycles + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios then random traffic vs a reference model.
module tb_hazard_scoreboard;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_id_valid;
    logic [4:0]  i_id_rs;
    logic [4:0]  i_id_rt;
    logic        i_id_rs_used;
    logic        i_id_rt_used;
    logic        i_id_wr_en;
    logic [4:0]  i_id_rd;
    logic [1:0]  i_id_lat;
    logic        i_jump;
    logic        i_branch_taken;
    logic        o_pc_keep;
    logic        o_IF_ID_keep;
    logic        o_IF_ID_flush;
    logic        o_ID_EX_flush;
    logic        o_busy;
    logic [31:0] o_stall_cycles;

    hazard_scoreboard dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_id_valid    (i_id_valid),
        .i_id_rs       (i_id_rs),
        .i_id_rt       (i_id_rt),
        .i_id_rs_used  (i_id_rs_used),
        .i_id_rt_used  (i_id_rt_used),
        .i_id_wr_en    (i_id_wr_en),
        .i_id_rd       (i_id_rd),
        .i_id_lat      (i_id_lat),
        .i_jump        (i_jump),
        .i_branch_taken(i_branch_taken),
        .o_pc_keep     (o_pc_keep),
        .o_IF_ID_keep  (o_IF_ID_keep),
        .o_IF_ID_flush (o_IF_ID_flush),
        .o_ID_EX_flush (o_ID_EX_flush),
        .o_busy        (o_busy),
        .o_stall_cycles(o_stall_cycles)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: cycles remaining before each register's result is forwardable.
    int          pending [32];
    int unsigned stall_count;
    int          checks;
    int          fails;

    function automatic bit m_stall();
        bit hit;
        hit = (i_id_rs_used && i_id_rs != 0 && pending[i_id_rs] > 0) ||
              (i_id_rt_used && i_id_rt != 0 && pending[i_id_rt] > 0);
        return i_rst_n && i_id_valid && hit && !i_branch_taken;
    endfunction

    function automatic bit m_busy();
        for (int r = 0; r < 32; r++) if (pending[r] > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 32; r++) pending[r] = 0;
        stall_count = 0;
    endtask

    task automatic model_edge();
        bit st;
        bit iss;
        int lat;
        if (!i_rst_n) begin
            model_clear();
            return;
        end
        st  = m_stall();
        iss = i_id_valid && !st && !i_branch_taken;
        lat = (int'(i_id_lat) > 3) ? 3 : int'(i_id_lat);
        for (int r = 1; r < 32; r++) begin
            if (iss && i_id_wr_en && int'(i_id_rd) == r) pending[r] = lat;
            else if (pending[r] > 0) pending[r] = pending[r] - 1;
        end
        if (st) stall_count = stall_count + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        bit st;
        st = m_stall();
        chk({tag, ".pc_keep"}, 32'(o_pc_keep), 32'(st));
        chk({tag, ".if_id_keep"}, 32'(o_IF_ID_keep), 32'(st));
        chk({tag, ".id_ex_flush"}, 32'(o_ID_EX_flush), 32'(st || (i_rst_n && i_branch_taken) || (!i_rst_n && i_branch_taken)));
        chk({tag, ".if_id_flush"}, 32'(o_IF_ID_flush), 32'(i_branch_taken || (i_jump && !st)));
        chk({tag, ".busy"}, 32'(o_busy), 32'(m_busy()));
        chk({tag, ".stall_cycles"}, o_stall_cycles, stall_count);
    endtask

    task automatic drive(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                         input bit wr, input int rd, input int lat, input bit j, input bit br);
        i_id_valid     = v;
        i_id_rs        = 5'(rs);
        i_id_rs_used   = rsu;
        i_id_rt        = 5'(rt);
        i_id_rt_used   = rtu;
        i_id_wr_en     = wr;
        i_id_rd        = 5'(rd);
        i_id_lat       = 2'(lat);
        i_jump         = j;
        i_branch_taken = br;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Inputs are applied just after a falling edge; outputs are sampled 1 ns later.
    task automatic step(input string tag);
        #1;
        check_model(tag);
        @(posedge i_clk);
        model_edge();
        @(negedge i_clk);
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        model_clear();
        i_rst_n = 1'b0;
        idle();
        #12;
        check_model("reset");
        chk("reset.busy_const", 32'(o_busy), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Load-use: lw $8 lat 1, then add reading $8 -> one bubble.
        drive(1, 1, 1, 2, 1, 1, 8, 1, 0, 0);  step("lu.lw");
        drive(1, 8, 1, 2, 1, 1, 10, 0, 0, 0); #1;
        chk("lu.stall_const", 32'(o_pc_keep), 32'd1);
        step("lu.add_stall");
        chk("lu.count_const", o_stall_cycles, 32'd1);
        step("lu.add_issue");
        chk("lu.issue_const", 32'(o_pc_keep), 32'd0);

        // Multi-cycle: mul $9 lat 3, consumer on rt -> three stalls.
        drive(1, 1, 1, 2, 1, 1, 9, 3, 0, 0);  step("mul.issue");
        drive(1, 4, 1, 9, 1, 1, 11, 0, 0, 0);
        for (int i = 0; i < 4; i++) step($sformatf("mul.cons%0d", i));
        chk("mul.count_const", o_stall_cycles, 32'd4);

        // Independent instruction behind a mul: no stall, busy for 3 cycles.
        drive(1, 1, 1, 2, 1, 1, 9, 3, 0, 0);  step("ind.mul");
        drive(1, 3, 1, 0, 0, 1, 12, 0, 0, 0);
        for (int i = 0; i < 4; i++) step($sformatf("ind.op%0d", i));

        // $0 destination and unused source.
        drive(1, 1, 1, 2, 1, 1, 0, 3, 0, 0);  step("r0.prod");
        idle();                               step("r0.after");
        chk("r0.busy_const", 32'(o_busy), 32'd0);
        drive(1, 1, 1, 2, 1, 1, 8, 1, 0, 0);  step("unused.lw");
        drive(1, 8, 0, 2, 1, 1, 13, 0, 0, 0); step("unused.cons");

        // Branch resolves while a consumer is stalled on $8.
        drive(1, 1, 1, 2, 1, 1, 8, 2, 0, 0);  step("br.lw");
        drive(1, 8, 1, 2, 1, 1, 14, 0, 0, 1); step("br.squash");
        idle();                               step("br.drain1");
        step("br.drain2");

        // WAW overwrite, then a lone jump.
        drive(1, 1, 1, 2, 1, 1, 8, 1, 0, 0);  step("waw.lw");
        drive(1, 5, 1, 0, 0, 1, 8, 0, 0, 0);  step("waw.addi");
        drive(1, 8, 1, 0, 0, 1, 15, 0, 0, 0); step("waw.reader");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);  step("jump.alone");
        drive(1, 8, 1, 8, 1, 1, 8, 3, 0, 0);  step("self.dep");
        drive(1, 8, 1, 0, 0, 0, 0, 0, 1, 0);  step("jump.stalled");

        // Asynchronous reset in the middle of a stall with timer[8]=2.
        idle();                               step("rst.drain");
        step("rst.drain2");
        drive(1, 1, 1, 2, 1, 1, 8, 3, 0, 0);  step("rst.mul");
        drive(1, 8, 1, 0, 0, 1, 16, 0, 0, 0); step("rst.stall");
        #2;
        i_rst_n = 1'b0;
        model_clear();
        #1;
        chk("rst.pc_keep_drop", 32'(o_pc_keep), 32'd0);
        check_model("rst.async");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step("rst.cons");
        chk("rst.count_const", o_stall_cycles, 32'd0);

        // Random traffic on a small register window so dependencies are frequent.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 9) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 1) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 1) != 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                  $urandom_range(0, 3),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
            step($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
